tile_boot_ctrl: RTL and testbench
=================================

TILE_BOOT_CTRL -- requirements
Module: tile_boot_ctrl

Interface
REQ-001 SHALL have parameter N_CORES, default 2, number of managed cores (legal range 1-8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, boot address width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, reset-hold count before release (legal range 1-255).
REQ-004 SHALL have parameter DEFAULT_BOOT_ADDR, default 32'h8000_0000, boot address after reset.
REQ-005 SHALL have port clk_core  input  1  sole clock, all logic on the rising edge.
REQ-006 SHALL have port arst_core  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_valid  input  1  command valid.
REQ-008 SHALL have port cfg_ready  output  1  command accept.
REQ-009 SHALL have port cfg_op  input  2  opcode: 0 SET_BOOT, 1 RELEASE, 2 HALT, 3 CLR_ERR.
REQ-010 SHALL have port cfg_core  input  3  target core index, SET_BOOT only.
REQ-011 SHALL have port cfg_wdata  input  ADDR_WIDTH  boot address (SET_BOOT) or core mask in bits [N_CORES-1:0] (RELEASE/HALT).
REQ-012 SHALL have port core_rst_n  output  N_CORES  per-core active-low reset.
REQ-013 SHALL have port core_boot_addr  output  N_CORES*ADDR_WIDTH  per-core boot address, core i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 SHALL have port core_running  output  N_CORES  per-core RUN indication.
REQ-015 SHALL have port cfg_err  output  1  sticky error flag.

Function
REQ-016 SHALL accept a command when cfg_valid and cfg_ready are both 1 on a rising edge; cfg_ready SHALL be 1 whenever reset is deasserted.
REQ-017 SHALL keep an independent FSM per core with states HELD, PREP and RUN.
REQ-018 In HELD, core_rst_n[i]=0 and core_running[i]=0; an accepted RELEASE with mask bit i set SHALL move core i to PREP and load its hold counter with HOLD_CYCLES.
REQ-019 In PREP, core_rst_n[i]=0; the counter SHALL decrement once per cycle, and the core SHALL enter RUN on the cycle after the counter reaches 0, giving exactly HOLD_CYCLES+1 cycles in PREP.
REQ-020 In RUN, core_rst_n[i]=1 and core_running[i]=1, both registered and changing on the same edge the state enters RUN.
REQ-021 An accepted HALT with mask bit i set SHALL move core i from PREP or RUN to HELD on the next edge; core_rst_n[i] SHALL be 0 from that edge onward.
REQ-022 RELEASE to a core in PREP or RUN, and HALT to a core in HELD, SHALL have no effect and SHALL not set cfg_err.
REQ-023 SET_BOOT SHALL update core_boot_addr[cfg_core] on the next edge only if that core is in HELD.
REQ-024 SET_BOOT targeting a core in PREP or RUN, or with cfg_core >= N_CORES, SHALL be dropped and SHALL set cfg_err.
REQ-025 Mask bits at or above N_CORES SHALL be ignored and SHALL set cfg_err if any is 1.
REQ-026 CLR_ERR SHALL clear cfg_err on the next edge.
REQ-027 If an error condition and CLR_ERR could coincide, only one command is accepted per cycle, so they cannot.
REQ-028 core_boot_addr SHALL be stable whenever the core is in PREP or RUN.
REQ-029 All state and outputs SHALL be registered; there is no combinational path from cfg_* to core_* outputs.

Reset
REQ-030 While arst_core=0, all FSMs SHALL be in HELD, core_rst_n=0, core_running=0, core_boot_addr=DEFAULT_BOOT_ADDR for every core, cfg_err=0 and cfg_ready=0, all asserted asynchronously.
REQ-031 Reset asserted mid-PREP or mid-RUN SHALL force the outputs of REQ-030 immediately, without waiting for a clock edge.
REQ-032 After reset deasserts, cores SHALL remain in HELD until an explicit RELEASE.

Verification
REQ-033 Reset deassert, no commands for 100 cycles -> core_rst_n=2'b00, both boot addresses 32'h8000_0000, cfg_err=0.
REQ-034 SET_BOOT core1 = 32'h9000_0100, then RELEASE mask 2'b10 -> core_boot_addr[1]=32'h9000_0100; core_rst_n[1] rises exactly 17 cycles after the RELEASE edge (HOLD_CYCLES=16); core 0 stays held.
REQ-035 Core0 in RUN, SET_BOOT core0 = 32'hA000_0000 -> address unchanged and cfg_err=1; then CLR_ERR -> cfg_err=0.
REQ-036 RELEASE mask 2'b11, HALT mask 2'b01 issued 5 cycles later -> core0 back in HELD with core_rst_n[0]=0 on the next edge; core1 reaches RUN on its original schedule.
REQ-037 Core in RUN, arst_core pulsed low between clock edges -> core_rst_n=0 and boot address=DEFAULT_BOOT_ADDR immediately; after release the core stays HELD.
REQ-038 RELEASE with mask 32'h4 (N_CORES=2) -> no state change and cfg_err=1.

Source files
------------

// File: rtl/tile_boot_ctrl.sv
// ----------------------------------------------------------------------------
// tile_boot_ctrl
//
// Boot sequencer for a tile of up to eight cores. A small command port lets
// firmware program each core's boot address while the core is held, then
// release cores into a timed reset-hold phase before they start running.
// Cores can be halted back into reset at any time.
//
// Ports
//   clk_core        sole clock, rising edge
//   arst_core       asynchronous active-low reset
//   cfg_valid       command valid
//   cfg_ready       command accept (high whenever out of reset, registered)
//   cfg_op          0 SET_BOOT, 1 RELEASE, 2 HALT, 3 CLR_ERR
//   cfg_core        target core for SET_BOOT
//   cfg_wdata       boot address (SET_BOOT) or core mask (RELEASE/HALT)
//   core_rst_n      per-core active-low reset
//   core_boot_addr  per-core boot address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   core_running    per-core RUN indication
//   cfg_err         sticky error flag, cleared by CLR_ERR
// ----------------------------------------------------------------------------
module tile_boot_ctrl #(
   parameter int                     N_CORES           = 2,
   parameter int                     ADDR_WIDTH        = 32,
   parameter int                     HOLD_CYCLES       = 16,
   parameter logic [ADDR_WIDTH-1:0]  DEFAULT_BOOT_ADDR = ADDR_WIDTH'(32'h8000_0000)
) (
   input  logic                          clk_core,
   input  logic                          arst_core,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [1:0]                    cfg_op,
   input  logic [2:0]                    cfg_core,
   input  logic [ADDR_WIDTH-1:0]         cfg_wdata,
   output logic [N_CORES-1:0]            core_rst_n,
   output logic [N_CORES*ADDR_WIDTH-1:0] core_boot_addr,
   output logic [N_CORES-1:0]            core_running,
   output logic                          cfg_err
);

   localparam logic [1:0] OP_SET_BOOT = 2'd0;
   localparam logic [1:0] OP_RELEASE  = 2'd1;
   localparam logic [1:0] OP_HALT     = 2'd2;
   localparam logic [1:0] OP_CLR_ERR  = 2'd3;

   typedef enum logic [1:0] {
      HELD = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2
   } core_state_t;

   logic                ready_q;
   logic                err_q;
   logic                accept;
   logic                mask_err;
   logic                core_oob;
   logic                target_held;
   logic [N_CORES-1:0]  held;

   assign accept   = cfg_valid & ready_q;
   // Any mask bit beyond the implemented cores is a programming error.
   assign mask_err = |(cfg_wdata >> N_CORES);
   assign core_oob = (int'(cfg_core) >= N_CORES);

   always_comb begin
      target_held = 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
         if (cfg_core == 3'(i)) target_held = held[i];
      end
   end

   // Command port control: ready comes up on the first edge after reset,
   // error flag is sticky until CLR_ERR.
   always_ff @(posedge clk_core or negedge arst_core) begin
      if (!arst_core) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (accept) begin
            unique case (cfg_op)
               OP_SET_BOOT: if (core_oob || !target_held) err_q <= 1'b1;
               OP_RELEASE,
               OP_HALT:     if (mask_err) err_q <= 1'b1;
               OP_CLR_ERR:  err_q <= 1'b0;
               default:     err_q <= err_q;
            endcase
         end
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;

   for (genvar i = 0; i < N_CORES; i++) begin : g_core
      core_state_t            state;
      logic [7:0]             cnt;
      logic                   rst_q;
      logic                   run_q;
      logic [ADDR_WIDTH-1:0]  boot_q;
      logic                   hit_release;
      logic                   hit_halt;
      logic                   hit_boot;

      assign hit_release = accept && (cfg_op == OP_RELEASE) && cfg_wdata[i];
      assign hit_halt    = accept && (cfg_op == OP_HALT)    && cfg_wdata[i];
      assign hit_boot    = accept && (cfg_op == OP_SET_BOOT) && (cfg_core == 3'(i));

      // Per-core FSM. The counter is loaded on the release edge and the core
      // only leaves PREP on the edge after it has counted down to zero, so
      // PREP lasts HOLD_CYCLES+1 cycles. Outputs are set on the transition
      // edges so they are registered and aligned with the state.
      always_ff @(posedge clk_core or negedge arst_core) begin
         if (!arst_core) begin
            state  <= HELD;
            cnt    <= '0;
            rst_q  <= 1'b0;
            run_q  <= 1'b0;
            boot_q <= DEFAULT_BOOT_ADDR;
         end else begin
            unique case (state)
               HELD: begin
                  if (hit_release) begin
                     state <= PREP;
                     cnt   <= 8'(HOLD_CYCLES);
                  end else if (hit_boot) begin
                     boot_q <= cfg_wdata;
                  end
               end
               PREP: begin
                  if (hit_halt) begin
                     state <= HELD;
                  end else if (cnt == 8'd0) begin
                     state <= RUN;
                     rst_q <= 1'b1;
                     run_q <= 1'b1;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               RUN: begin
                  if (hit_halt) begin
                     state <= HELD;
                     rst_q <= 1'b0;
                     run_q <= 1'b0;
                  end
               end
               default: begin
                  state <= HELD;
                  rst_q <= 1'b0;
                  run_q <= 1'b0;
               end
            endcase
         end
      end

      assign held[i]         = (state == HELD);
      assign core_rst_n[i]   = rst_q;
      assign core_running[i] = run_q;
      assign core_boot_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = boot_q;
   end

endmodule

// File: tb/tb_tile_boot_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tile_boot_ctrl
//
// Directed bench for tile_boot_ctrl with a timeline model: each core is
// described only by how many edges have passed since it was released
// (-1 while held); a core is running once that count reaches HOLD+1.
// A compare process checks every output against the model on each falling
// edge, and directed sequences pin key values with literal expectations.
// ----------------------------------------------------------------------------
module tb_tile_boot_ctrl;
   localparam int          N    = 2;
   localparam int          AW   = 32;
   localparam int          HOLD = 16;
   localparam logic [31:0] DEF  = 32'h8000_0000;

   logic            clk_core  = 1'b0;
   logic            arst_core = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [1:0]      cfg_op    = 2'd0;
   logic [2:0]      cfg_core  = 3'd0;
   logic [31:0]     cfg_wdata = 32'd0;
   logic [N-1:0]    core_rst_n;
   logic [N*AW-1:0] core_boot_addr;
   logic [N-1:0]    core_running;
   logic            cfg_err;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk_core = ~clk_core;

   tile_boot_ctrl #(
      .N_CORES(N),
      .ADDR_WIDTH(AW),
      .HOLD_CYCLES(HOLD),
      .DEFAULT_BOOT_ADDR(DEF)
   ) dut (
      .clk_core(clk_core),
      .arst_core(arst_core),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_op(cfg_op),
      .cfg_core(cfg_core),
      .cfg_wdata(cfg_wdata),
      .core_rst_n(core_rst_n),
      .core_boot_addr(core_boot_addr),
      .core_running(core_running),
      .cfg_err(cfg_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          elapsed [N];
   logic [31:0] m_boot  [N];
   logic        m_err;
   logic        m_ready;

   function automatic logic [N-1:0] exp_run();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (elapsed[i] >= HOLD + 1);
      return v;
   endfunction

   function automatic logic [N*AW-1:0] exp_boot();
      logic [N*AW-1:0] v;
      for (int i = 0; i < N; i++) v[i*AW +: AW] = m_boot[i];
      return v;
   endfunction

   initial begin : model
      bit acc;
      int ci;
      for (int i = 0; i < N; i++) begin
         elapsed[i] = -1;
         m_boot[i]  = DEF;
      end
      m_err   = 1'b0;
      m_ready = 1'b0;
      forever begin
         @(posedge clk_core or negedge arst_core);
         if (!arst_core) begin
            for (int i = 0; i < N; i++) begin
               elapsed[i] = -1;
               m_boot[i]  = DEF;
            end
            m_err   = 1'b0;
            m_ready = 1'b0;
         end else begin
            acc = cfg_valid && m_ready;
            for (int i = 0; i < N; i++) if (elapsed[i] >= 0) elapsed[i]++;
            if (acc) begin
               case (cfg_op)
                  2'd0: begin
                     ci = int'(cfg_core);
                     if (ci < N && elapsed[ci] < 0) m_boot[ci] = cfg_wdata;
                     else m_err = 1'b1;
                  end
                  2'd1: begin
                     for (int i = 0; i < N; i++) if (cfg_wdata[i] && elapsed[i] < 0) elapsed[i] = 0;
                     if ((cfg_wdata >> N) != 0) m_err = 1'b1;
                  end
                  2'd2: begin
                     for (int i = 0; i < N; i++) if (cfg_wdata[i]) elapsed[i] = -1;
                     if ((cfg_wdata >> N) != 0) m_err = 1'b1;
                  end
                  default: m_err = 1'b0;
               endcase
            end
            m_ready = 1'b1;
         end
      end
   end

   always @(negedge clk_core) begin
      if (cmp_en) begin
         check("model_rst_n",   64'(core_rst_n),     64'(exp_run()));
         check("model_running", 64'(core_running),   64'(exp_run()));
         check("model_boot",    64'(core_boot_addr), 64'(exp_boot()));
         check("model_err",     64'(cfg_err),        64'(m_err));
         check("model_ready",   64'(cfg_ready),      64'(m_ready));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cmd(input logic [1:0] op, input logic [2:0] core, input logic [31:0] wd);
      @(negedge clk_core);
      cfg_valid = 1'b1;
      cfg_op    = op;
      cfg_core  = core;
      cfg_wdata = wd;
      @(posedge clk_core);
      #1;
      cfg_valid = 1'b0;
   endtask

   // Returns the edge index (counting from the accept edge as 0) at which
   // core_rst_n[b] is first seen high; -1 if it never rises within budget.
   task automatic rise_edge(input int b, input int start, output int k_out);
      k_out = -1;
      for (int k = start; k <= 40; k++) begin
         @(posedge clk_core);
         #1;
         if (core_rst_n[b]) begin
            k_out = k;
            break;
         end
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int k;
      #1 arst_core = 1'b0;
      cmp_en = 1'b1;
      #11;
      check("reset_ready", 64'(cfg_ready),  64'd0);
      check("reset_rst_n", 64'(core_rst_n), 64'd0);
      #10 arst_core = 1'b1;

      // Idle after reset: everything held at defaults.
      repeat (100) @(posedge clk_core);
      #1;
      check("idle_rst_n", 64'(core_rst_n), 64'd0);
      check("idle_boot",  64'(core_boot_addr), {DEF, DEF});
      check("idle_err",   64'(cfg_err), 64'd0);
      check("idle_ready", 64'(cfg_ready), 64'd1);

      // Program core 1 and release it alone.
      cmd(2'd0, 3'd1, 32'h9000_0100);
      check("set_boot_core1", 64'(core_boot_addr[AW +: AW]), 64'h9000_0100);
      cmd(2'd1, 3'd0, 32'h2);
      rise_edge(1, 1, k);
      check("release_latency", 64'(k), 64'd17);
      check("core0_still_held", 64'(core_rst_n), 64'b10);
      check("running_core1", 64'(core_running), 64'b10);

      // Boot address locked while running.
      cmd(2'd1, 3'd0, 32'h1);
      repeat (20) @(posedge clk_core);
      cmd(2'd0, 3'd0, 32'hA000_0000);
      check("locked_boot0", 64'(core_boot_addr[0 +: AW]), 64'(DEF));
      check("locked_err",   64'(cfg_err), 64'd1);
      cmd(2'd3, 3'd0, 32'h0);
      check("clr_err", 64'(cfg_err), 64'd0);

      // Redundant RELEASE / HALT are harmless.
      cmd(2'd1, 3'd0, 32'h3);
      check("rerelease_err", 64'(cfg_err), 64'd0);
      check("rerelease_run", 64'(core_running), 64'b11);
      cmd(2'd2, 3'd0, 32'h3);
      check("halt_run_rst_n", 64'(core_rst_n), 64'b00);
      cmd(2'd2, 3'd0, 32'h1);
      check("halt_held_err", 64'(cfg_err), 64'd0);

      // Release both, halt core 0 five cycles later.
      cmd(2'd1, 3'd0, 32'h3);
      repeat (4) @(posedge clk_core);
      cmd(2'd2, 3'd0, 32'h1);
      check("halt_prep_rst_n0", 64'(core_rst_n[0]), 64'd0);
      rise_edge(1, 6, k);
      check("core1_schedule", 64'(k), 64'd17);
      check("core0_halted", 64'(core_rst_n), 64'b10);

      // Asynchronous reset pulse between edges while core 1 runs.
      @(posedge clk_core);
      #2 arst_core = 1'b0;
      #1;
      check("async_rst_n",   64'(core_rst_n), 64'd0);
      check("async_running", 64'(core_running), 64'd0);
      check("async_boot",    64'(core_boot_addr), {DEF, DEF});
      check("async_ready",   64'(cfg_ready), 64'd0);
      #1 arst_core = 1'b1;
      repeat (30) @(posedge clk_core);
      #1;
      check("post_reset_held", 64'(core_rst_n), 64'd0);

      // Out-of-range mask bit and out-of-range core index.
      cmd(2'd1, 3'd0, 32'h4);
      check("mask_oob_err", 64'(cfg_err), 64'd1);
      repeat (20) @(posedge clk_core);
      #1;
      check("mask_oob_nochange", 64'(core_rst_n), 64'd0);
      cmd(2'd3, 3'd0, 32'h0);
      cmd(2'd0, 3'd5, 32'h1234_5678);
      check("core_oob_err",  64'(cfg_err), 64'd1);
      check("core_oob_boot", 64'(core_boot_addr), {DEF, DEF});
      cmd(2'd3, 3'd0, 32'h0);
      check("final_err", 64'(cfg_err), 64'd0);

      repeat (3) @(posedge clk_core);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
